// File: rtl/ysyx_23060111_wb_arb_pkg.sv
// rtl/ysyx_23060111_wb_arb_pkg.sv - shared widths and requester indices for the writeback arbiter
package ysyx_23060111_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    // Requester indices, also the encoding of the round-robin pointer
    localparam logic WB_EXU = 1'b0;
    localparam logic WB_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060111_wb_arb_if.sv
// rtl/ysyx_23060111_wb_arb_if.sv - writeback/scoreboard bus bundle (bypass ports under YSYX_23060111_WB_BYPASS_EN)
interface ysyx_23060111_wb_arb_if
    import ysyx_23060111_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    // EXU writeback port
    logic                  r0_valid;
    logic                  r0_ready;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_data;

    // LSU writeback port
    logic                  r1_valid;
    logic                  r1_ready;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_data;

    // IDU issue and hazard queries
    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic [ADDR_WIDTH-1:0] q_rs1;
    logic [ADDR_WIDTH-1:0] q_rs2;
    logic [ADDR_WIDTH-1:0] q_rd;
    logic                  busy_rs1;
    logic                  busy_rs2;
    logic                  busy_rd;

    // Register-file write port
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

`ifdef YSYX_23060111_WB_BYPASS_EN
    logic                  byp_rs1_hit;
    logic                  byp_rs2_hit;
    logic [DATA_WIDTH-1:0] byp_data;
`endif

    // Producers, IDU and register file side
    modport master (
        output r0_valid, r0_addr, r0_data, input r0_ready,
        output r1_valid, r1_addr, r1_data, input r1_ready,
        output iss_valid, iss_rd, q_rs1, q_rs2, q_rd,
        input  busy_rs1, busy_rs2, busy_rd,
`ifdef YSYX_23060111_WB_BYPASS_EN
        input  byp_rs1_hit, byp_rs2_hit, byp_data,
`endif
        input  rf_wen, rf_waddr, rf_wdata
    );

    // Arbiter side
    modport slave (
        input  r0_valid, r0_addr, r0_data, output r0_ready,
        input  r1_valid, r1_addr, r1_data, output r1_ready,
        input  iss_valid, iss_rd, q_rs1, q_rs2, q_rd,
        output busy_rs1, busy_rs2, busy_rd,
`ifdef YSYX_23060111_WB_BYPASS_EN
        output byp_rs1_hit, byp_rs2_hit, byp_data,
`endif
        output rf_wen, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/ysyx_23060111_wb_arb_sb.sv
// rtl/ysyx_23060111_wb_arb_sb.sv - register busy-bit scoreboard (query masking under YSYX_23060111_WB_BYPASS_EN)
module ysyx_23060111_wb_sb
    import ysyx_23060111_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic [ADDR_WIDTH-1:0] q_rs1,
    input  logic [ADDR_WIDTH-1:0] q_rs2,
    input  logic [ADDR_WIDTH-1:0] q_rd,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  busy_rd
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy vector: clear first so an issue to the same index wins; x0 never busy
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != '0)) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy-bit storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Queries see state only; with bypass, the index being written this cycle reads free
    always_comb begin
        busy_rs1 = busy_q[q_rs1];
        busy_rs2 = busy_q[q_rs2];
        busy_rd  = busy_q[q_rd];
`ifdef YSYX_23060111_WB_BYPASS_EN
        if (clr_en && (q_rs1 == clr_idx)) busy_rs1 = 1'b0;
        if (clr_en && (q_rs2 == clr_idx)) busy_rs2 = 1'b0;
        if (clr_en && (q_rd  == clr_idx)) busy_rd  = 1'b0;
`endif
    end

endmodule

// File: rtl/ysyx_23060111_wb_arb.sv
// rtl/ysyx_23060111_wb_arb.sv - EXU/LSU round-robin writeback arbiter with scoreboard (optional YSYX_23060111_WB_BYPASS_EN)
module ysyx_23060111_wb_arb
    import ysyx_23060111_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ysyx_23060111_wb_arb_if.slave   bus
);

    logic                  ptr_q,      ptr_d;
    logic                  rf_wen_q,   rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic                  gnt0;
    logic                  gnt1;

    // Grant: the pointer only matters when both producers are valid
    always_comb begin
        gnt0 = bus.r0_valid && (!bus.r1_valid || (ptr_q == WB_EXU));
        gnt1 = bus.r1_valid && (!bus.r0_valid || (ptr_q == WB_LSU));
    end

    // No backpressure downstream, so ready is just the grant, gated off in reset
    assign bus.r0_ready = rst_n && gnt0;
    assign bus.r1_ready = rst_n && gnt1;

    // Next pointer and write stage; x0 transfers complete but never enable the write
    always_comb begin
        ptr_d      = ptr_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (gnt0) begin
            ptr_d      = WB_LSU;
            rf_wen_d   = (bus.r0_addr != '0);
            rf_waddr_d = bus.r0_addr;
            rf_wdata_d = bus.r0_data;
        end else if (gnt1) begin
            ptr_d      = WB_EXU;
            rf_wen_d   = (bus.r1_addr != '0);
            rf_waddr_d = bus.r1_addr;
            rf_wdata_d = bus.r1_data;
        end
    end

    // Pointer and registered write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= WB_EXU;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

    ysyx_23060111_wb_sb #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (bus.iss_valid),
        .set_idx  (bus.iss_rd),
        .clr_en   (rf_wen_q),
        .clr_idx  (rf_waddr_q),
        .q_rs1    (bus.q_rs1),
        .q_rs2    (bus.q_rs2),
        .q_rd     (bus.q_rd),
        .busy_rs1 (bus.busy_rs1),
        .busy_rs2 (bus.busy_rs2),
        .busy_rd  (bus.busy_rd)
    );

`ifdef YSYX_23060111_WB_BYPASS_EN
    assign bus.byp_rs1_hit = rf_wen_q && (bus.q_rs1 == rf_waddr_q);
    assign bus.byp_rs2_hit = rf_wen_q && (bus.q_rs2 == rf_waddr_q);
    assign bus.byp_data    = rf_wdata_q;
`endif

endmodule

// File: tb/tb_ysyx_23060111_wb_arb.sv
// tb/tb_ysyx_23060111_wb_arb.sv - self-checking bench for the writeback arbiter and scoreboard
module tb_ysyx_23060111_wb_arb;

    logic clk;
    logic rst_n;

    ysyx_23060111_wb_arb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    ysyx_23060111_wb_arb #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register busy set, last writer, pending write
    logic [31:0] busy_m;
    logic        prefer_lsu;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        model_ok = 1'b0;

    // Observed values of the most recent cycle
    logic o_r0, o_r1, o_wen, o_b1, o_b2, o_b3;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_exp(input logic [4:0] q);
        logic b;
        b = busy_m[q];
`ifdef YSYX_23060111_WB_BYPASS_EN
        if (exp_wen && (q == exp_waddr)) b = 1'b0;
`endif
        return b;
    endfunction

    // One clock: drive after negedge, check, advance model, move to the next negedge
    task automatic cycle(input logic rst, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic iss, input logic [4:0] rd,
                         input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] q3);
        logic e0, e1;
        rst_n = rst;
        bus.r0_valid = v0; bus.r0_addr = a0; bus.r0_data = d0;
        bus.r1_valid = v1; bus.r1_addr = a1; bus.r1_data = d1;
        bus.iss_valid = iss; bus.iss_rd = rd;
        bus.q_rs1 = q1; bus.q_rs2 = q2; bus.q_rd = q3;
        #1;
        e0 = rst && v0 && (!v1 || !prefer_lsu);
        e1 = rst && v1 && (!v0 || prefer_lsu);
        o_r0 = bus.r0_ready; o_r1 = bus.r1_ready;
        o_wen = bus.rf_wen; o_waddr = bus.rf_waddr; o_wdata = bus.rf_wdata;
        o_b1 = bus.busy_rs1; o_b2 = bus.busy_rs2; o_b3 = bus.busy_rd;
        chk1("r0_ready", o_r0, e0);
        chk1("r1_ready", o_r1, e1);
        if (model_ok) begin
            chk1("rf_wen", o_wen, exp_wen);
            chkw("rf_waddr", 32'(o_waddr), 32'(exp_waddr));
            chkw("rf_wdata", o_wdata, exp_wdata);
            chk1("busy_rs1", o_b1, busy_exp(q1));
            chk1("busy_rs2", o_b2, busy_exp(q2));
            chk1("busy_rd", o_b3, busy_exp(q3));
`ifdef YSYX_23060111_WB_BYPASS_EN
            chk1("byp_rs1_hit", bus.byp_rs1_hit, exp_wen && (q1 == exp_waddr));
            chk1("byp_rs2_hit", bus.byp_rs2_hit, exp_wen && (q2 == exp_waddr));
            chkw("byp_data", bus.byp_data, exp_wdata);
`endif
        end
        if (!rst) begin
            busy_m = '0; prefer_lsu = 1'b0;
            exp_wen = 1'b0; exp_waddr = '0; exp_wdata = '0;
            model_ok = 1'b1;
        end else begin
            if (exp_wen) busy_m[exp_waddr] = 1'b0;
            if (iss && (rd != 5'd0)) busy_m[rd] = 1'b1;
            if (e0) begin
                exp_wen = (a0 != 5'd0); exp_waddr = a0; exp_wdata = d0; prefer_lsu = 1'b1;
            end else if (e1) begin
                exp_wen = (a1 != 5'd0); exp_waddr = a1; exp_wdata = d1; prefer_lsu = 1'b0;
            end else begin
                exp_wen = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] q3);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, q1, q2, q3);
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] q1);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, rd, q1, 5'd0, rd);
    endtask

    initial begin
        prefer_lsu = 1'b0; busy_m = '0; exp_wen = 1'b0; exp_waddr = '0; exp_wdata = '0;
        rst_n = 1'b0;
        bus.r0_valid = 1'b0; bus.r0_addr = '0; bus.r0_data = '0;
        bus.r1_valid = 1'b0; bus.r1_addr = '0; bus.r1_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.q_rs1 = '0; bus.q_rs2 = '0; bus.q_rd = '0;
        @(negedge clk);

        // Reset held with both producers valid
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 5'd0, 5'd5, 5'd6, 5'd7);
            chk1("rst_r0_ready", o_r0, 1'b0);
            chk1("rst_r1_ready", o_r1, 1'b0);
        end
        idle(5'd5, 5'd6, 5'd7);
        chk1("post_rst_wen", o_wen, 1'b0);
        chk1("post_rst_busy", o_b1 | o_b2 | o_b3, 1'b0);

        // Contention: grants alternate starting with EXU
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
            chk1("contend_r0", o_r0, (i % 2) == 0);
            chk1("contend_r1", o_r1, (i % 2) == 1);
            if (i > 0) chkw("contend_waddr", 32'(o_waddr), (i % 2) == 1 ? 32'd5 : 32'd6);
        end
        idle(5'd0, 5'd0, 5'd0);
        chk1("contend_last_wen", o_wen, 1'b1);
        chkw("contend_last_wdata", o_wdata, 32'h22);

        // x0 write completes but never enables; issuing rd=0 does not mark busy
        cycle(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
        chk1("x0_ready", o_r0, 1'b1);
        idle(5'd0, 5'd0, 5'd0);
        chk1("x0_wen", o_wen, 1'b0);
        chk1("x0_busy_rd", o_b3, 1'b0);

        // Scoreboard timing on x7
        issue(5'd7, 5'd7);
        idle(5'd7, 5'd0, 5'd0);
        chk1("sb_busy_c1", o_b1, 1'b1);
        idle(5'd7, 5'd0, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0);
        chk1("sb_lsu_ready", o_r1, 1'b1);
        idle(5'd7, 5'd0, 5'd0);
        chk1("sb_wen_c4", o_wen, 1'b1);
        chk1("sb_busy_c4", o_b1, 1'b1 `ifdef YSYX_23060111_WB_BYPASS_EN & 1'b0 `endif);
        idle(5'd7, 5'd0, 5'd0);
        chk1("sb_busy_c5", o_b1, 1'b0);

        // Issue to the index being cleared: set wins
        issue(5'd7, 5'd7);
        cycle(1'b1, 1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0);
        issue(5'd7, 5'd7);
        idle(5'd7, 5'd0, 5'd0);
        chk1("sb_set_wins", o_b1, 1'b1);

        // Reset during an in-flight write
        issue(5'd3, 5'd3);
        cycle(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd7, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd7, 5'd0);
        idle(5'd3, 5'd7, 5'd0);
        chk1("midrst_wen", o_wen, 1'b0);
        chk1("midrst_busy3", o_b1, 1'b0);
        chk1("midrst_busy7", o_b2, 1'b0);

        // Write x9 and query it in the write cycle
        issue(5'd9, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd9, 5'd0);
        idle(5'd0, 5'd9, 5'd0);
`ifdef YSYX_23060111_WB_BYPASS_EN
        chk1("byp_busy_rs2", o_b2, 1'b0);
        chk1("byp_rs2_hit_dir", bus.byp_rs2_hit, 1'b1);
        chkw("byp_data_dir", bus.byp_data, 32'h1234);
`else
        chk1("nobyp_busy_rs2", o_b2, 1'b1);
`endif
        idle(5'd0, 5'd9, 5'd0);
        chk1("x9_free", o_b2, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 63) != 0,
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
